// File: rtl/mul_seq_pkg.sv
// Shared types and helpers for the digit-serial multiply sequencer.
package mul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int CORE_W = 4;

  // Core passes needed for an opw x opw product.
  function automatic int npass(input int opw);
    return (opw / CORE_W) * (opw / CORE_W);
  endfunction

  // Extract 4-bit digit idx of v; operands up to 64 bits wide are supported.
  function automatic logic [CORE_W-1:0] digit(input logic [63:0] v, input int idx);
    return CORE_W'(v >> (CORE_W * idx));
  endfunction

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Request/response handshake bundle between a requester and mul_seq_ctrl.
interface mul_seq_ctrl_if #(
  parameter int OPW = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   in_a;
  logic [OPW-1:0]   in_b;
  logic             out_valid;
  logic             out_ready;
  logic [2*OPW-1:0] out_p;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Sequences an OPW x OPW unsigned multiply through an external 4x4 core, one digit pair per cycle.
// Optional MUL_SEQ_ZERO_BYPASS_EN: zero operands skip the core and complete one edge after accept.
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int OPW = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mul_seq_ctrl_if.slave         bus,
  output logic                  busy,
  output logic [CORE_W-1:0]     core_x,
  output logic [CORE_W-1:0]     core_y,
  input  logic [2*CORE_W-1:0]   core_o
);

  localparam int NB    = OPW / CORE_W;
  localparam int NPASS = npass(OPW);
  localparam int CW    = $clog2(NPASS + 1);
  localparam int PW    = 2 * OPW;

  state_e              state_r, state_nxt;
  logic [PW-1:0]       acc_r, acc_nxt;
  logic [PW-1:0]       p_r, p_nxt;
  logic [CW-1:0]       cnt_r, cnt_nxt;
  logic [OPW-1:0]      a_r, a_nxt;
  logic [OPW-1:0]      b_r, b_nxt;
  logic [CORE_W-1:0]   cx_r, cx_nxt;
  logic [CORE_W-1:0]   cy_r, cy_nxt;
  logic [PW-1:0]       term_s;
  logic                last_s;
  int                  ci_s, cj_s, ni_s, nj_s;

  // Digit indices of the current and next pass, and the aligned partial product.
  always_comb begin
    ci_s   = int'(cnt_r) / NB;
    cj_s   = int'(cnt_r) % NB;
    ni_s   = (int'(cnt_r) + 1) / NB;
    nj_s   = (int'(cnt_r) + 1) % NB;
    term_s = PW'(core_o) << (CORE_W * (ci_s + cj_s));
    last_s = (cnt_r == CW'(NPASS - 1));
  end

  // Next-state and datapath update; core digits are registered one pass ahead.
  always_comb begin
    state_nxt = state_r;
    acc_nxt   = acc_r;
    p_nxt     = p_r;
    cnt_nxt   = cnt_r;
    a_nxt     = a_r;
    b_nxt     = b_r;
    cx_nxt    = cx_r;
    cy_nxt    = cy_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          a_nxt   = bus.in_a;
          b_nxt   = bus.in_b;
          acc_nxt = '0;
          cnt_nxt = '0;
`ifdef MUL_SEQ_ZERO_BYPASS_EN
          if ((bus.in_a == '0) || (bus.in_b == '0)) begin
            state_nxt = DONE;
            p_nxt     = '0;
            cx_nxt    = '0;
            cy_nxt    = '0;
          end else begin
            state_nxt = RUN;
            cx_nxt    = digit(64'(bus.in_a), 0);
            cy_nxt    = digit(64'(bus.in_b), 0);
          end
`else
          state_nxt = RUN;
          cx_nxt    = digit(64'(bus.in_a), 0);
          cy_nxt    = digit(64'(bus.in_b), 0);
`endif
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        acc_nxt = acc_r + term_s;
        if (last_s) begin
          state_nxt = DONE;
          p_nxt     = acc_r + term_s;
          cx_nxt    = '0;
          cy_nxt    = '0;
        end else begin
          state_nxt = RUN;
          cnt_nxt   = cnt_r + CW'(1);
          cx_nxt    = digit(64'(a_r), ni_s);
          cy_nxt    = digit(64'(b_r), nj_s);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cx_nxt    = '0;
        cy_nxt    = '0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      acc_r   <= '0;
      p_r     <= '0;
      cnt_r   <= '0;
      a_r     <= '0;
      b_r     <= '0;
      cx_r    <= '0;
      cy_r    <= '0;
    end else begin
      state_r <= state_nxt;
      acc_r   <= acc_nxt;
      p_r     <= p_nxt;
      cnt_r   <= cnt_nxt;
      a_r     <= a_nxt;
      b_r     <= b_nxt;
      cx_r    <= cx_nxt;
      cy_r    <= cy_nxt;
    end
  end

  assign bus.in_ready  = (state_r == IDLE);
  assign bus.out_valid = (state_r == DONE);
  assign bus.out_p     = p_r;
  assign busy          = (state_r != IDLE);
  assign core_x        = cx_r;
  assign core_y        = cy_r;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed self-checking bench for mul_seq_ctrl with a behavioural 4x4 core alongside.
module tb_mul_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic [3:0] core_x, core_y;
  logic [7:0] core_o;
  int         n_pass = 0;
  int         n_total = 0;

  mul_seq_ctrl_if #(.OPW(8)) bus ();

  mul_seq_ctrl #(.OPW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy),
    .core_x(core_x),
    .core_y(core_y),
    .core_o(core_o)
  );

  // 4x4 combinational multiplier core
  assign core_o = {4'd0, core_x} * {4'd0, core_y};

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = 8'd0; bus.in_b = 8'd0; bus.out_ready = 1'b0;
    #12;
    n_total++;
    if ({busy, bus.out_valid, bus.out_p, core_x, core_y} !== 26'd0)
      $display("FAIL reset_outputs got %b exp 0", {busy, bus.out_valid, bus.out_p, core_x, core_y});
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    tick;
    n_total++;
    if ({bus.in_ready, busy, bus.out_valid} !== 3'b100)
      $display("FAIL reset_idle got %b exp 100", {bus.in_ready, busy, bus.out_valid});
    else n_pass++;
  endtask

  task automatic test_vectors;
    logic [7:0]  va[2] = '{8'hFF, 8'h0D};
    logic [7:0]  vb[2] = '{8'hFF, 8'hB7};
    logic [15:0] vp[2] = '{16'hFE01, 16'h094B};
    logic [7:0]  vpair[2][4] = '{'{8'hFF, 8'hFF, 8'hFF, 8'hFF}, '{8'hD7, 8'hDB, 8'h07, 8'h0B}};
    for (int v = 0; v < 2; v++) begin
      bus.in_a = va[v]; bus.in_b = vb[v]; bus.in_valid = 1'b1;
      tick;
      bus.in_valid = 1'b0;
      n_total++;
      if ({busy, bus.in_ready} !== 2'b10)
        $display("FAIL vec%0d_run got %b exp 10", v, {busy, bus.in_ready});
      else n_pass++;
      for (int k = 0; k < 4; k++) begin
        n_total++;
        if ({bus.out_valid, core_x, core_y} !== {1'b0, vpair[v][k]})
          $display("FAIL vec%0d_pass%0d got %h exp %h", v, k, {bus.out_valid, core_x, core_y}, {1'b0, vpair[v][k]});
        else n_pass++;
        tick;
      end
      n_total++;
      if (bus.out_valid !== 1'b1) $display("FAIL vec%0d_valid got %b exp 1", v, bus.out_valid);
      else n_pass++;
      n_total++;
      if (bus.out_p !== vp[v]) $display("FAIL vec%0d_p got %h exp %h", v, bus.out_p, vp[v]);
      else n_pass++;
      n_total++;
      if ({core_x, core_y} !== 8'h00) $display("FAIL vec%0d_core_done got %h exp 00", v, {core_x, core_y});
      else n_pass++;
      bus.out_ready = 1'b1;
      tick;
      bus.out_ready = 1'b0;
      n_total++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01)
        $display("FAIL vec%0d_handshake got %b exp 01", v, {bus.out_valid, bus.in_ready});
      else n_pass++;
    end
  endtask

  task automatic test_hold;
    int n = 0;
    bus.in_a = 8'h21; bus.in_b = 8'h03; bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    while (bus.out_valid !== 1'b1 && n < 20) begin tick; n++; end
    n_total++;
    if (n !== 4) $display("FAIL hold_latency got %0d exp 4", n);
    else n_pass++;
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1; bus.in_a = 8'hAA; bus.in_b = 8'h55;
      tick;
      n_total++;
      if ({bus.out_valid, bus.in_ready, bus.out_p} !== {2'b10, 16'h0063})
        $display("FAIL hold_c%0d got %h exp %h", c, {bus.out_valid, bus.in_ready, bus.out_p}, {2'b10, 16'h0063});
      else n_pass++;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    n_total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01)
      $display("FAIL hold_release got %b exp 01", {bus.out_valid, bus.in_ready});
    else n_pass++;
    tick;
    n_total++;
    if (busy !== 1'b0) $display("FAIL hold_ignored got busy %b exp 0", busy);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int n = 0;
    bus.out_ready = 1'b1;
    bus.in_a = 8'd3; bus.in_b = 8'd5; bus.in_valid = 1'b1;
    tick;
    bus.in_a = 8'd200; bus.in_b = 8'd100;
    while (bus.out_valid !== 1'b1 && n < 20) begin tick; n++; end
    n_total++;
    if ({n[7:0], bus.out_p} !== {8'd4, 16'h000F})
      $display("FAIL b2b_first got n=%0d p=%h exp n=4 p=000f", n, bus.out_p);
    else n_pass++;
    tick;
    n_total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01)
      $display("FAIL b2b_gap got %b exp 01", {bus.out_valid, bus.in_ready});
    else n_pass++;
    tick;
    bus.in_valid = 1'b0;
    n_total++;
    if (busy !== 1'b1) $display("FAIL b2b_accept got busy %b exp 1", busy);
    else n_pass++;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin tick; n++; end
    n_total++;
    if ({n[7:0], bus.out_p} !== {8'd4, 16'h4E20})
      $display("FAIL b2b_second got n=%0d p=%h exp n=4 p=4e20", n, bus.out_p);
    else n_pass++;
    tick;
    bus.out_ready = 1'b0;
    n_total++;
    if (bus.out_valid !== 1'b0) $display("FAIL b2b_drain got %b exp 0", bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int  n = 0;
    logic seen = 1'b0;
    bus.in_a = 8'h12; bus.in_b = 8'h34; bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    tick;
    tick;
    n_total++;
    if ({core_x, core_y} !== 8'h14) $display("FAIL rst_mid_pass2 got %h exp 14", {core_x, core_y});
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({busy, bus.out_valid, bus.in_ready, core_x, core_y, bus.out_p} !== {3'b001, 24'd0})
      $display("FAIL rst_mid_outputs got %h exp %h", {busy, bus.out_valid, bus.in_ready, core_x, core_y, bus.out_p}, {3'b001, 24'd0});
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    n_total++;
    if (seen !== 1'b0) $display("FAIL rst_mid_dropped got out_valid seen %b exp 0", seen);
    else n_pass++;
    bus.in_a = 8'h12; bus.in_b = 8'h34; bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    while (bus.out_valid !== 1'b1 && n < 20) begin tick; n++; end
    n_total++;
    if ({n[7:0], bus.out_p} !== {8'd4, 16'h03A8})
      $display("FAIL rst_mid_retry got n=%0d p=%h exp n=4 p=03a8", n, bus.out_p);
    else n_pass++;
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_zero;
    bus.in_a = 8'h00; bus.in_b = 8'h5A; bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
`ifdef MUL_SEQ_ZERO_BYPASS_EN
    n_total++;
    if ({bus.out_valid, core_x, core_y} !== 9'h100)
      $display("FAIL zero_bypass got %h exp 100", {bus.out_valid, core_x, core_y});
    else n_pass++;
`else
    begin
      logic [7:0] zpair[4] = '{8'h0A, 8'h05, 8'h0A, 8'h05};
      for (int k = 0; k < 4; k++) begin
        n_total++;
        if ({bus.out_valid, core_x, core_y} !== {1'b0, zpair[k]})
          $display("FAIL zero_pass%0d got %h exp %h", k, {bus.out_valid, core_x, core_y}, {1'b0, zpair[k]});
        else n_pass++;
        tick;
      end
      n_total++;
      if (bus.out_valid !== 1'b1) $display("FAIL zero_valid got %b exp 1", bus.out_valid);
      else n_pass++;
    end
`endif
    n_total++;
    if (bus.out_p !== 16'h0000) $display("FAIL zero_p got %h exp 0000", bus.out_p);
    else n_pass++;
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    n_total++;
    if (bus.in_ready !== 1'b1) $display("FAIL zero_handshake got %b exp 1", bus.in_ready);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_hold;
    test_back_to_back;
    test_reset_mid;
    test_zero;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Multi-cycle sequencer that computes an OPW x OPW unsigned product using one shared 4x4 combinational multiplier core.
- Splits both operands into 4-bit digits and drives one digit pair per cycle into the core.
- Accumulates the shifted core outputs into a 2*OPW result.
- Sits between a valid/ready requester and the external 4x4 core; owns the core's inputs and reads its 8-bit output.

Parameters:
- OPW, 8, operand width in bits; must be a multiple of 4 and at least 4.
- NB (derived, not overridable), OPW/4, digits per operand.
- NPASS (derived), NB*NB, core passes per multiply (4 at default).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request operands valid
- in_ready  out  1  block can accept a request
- in_a  in  OPW  multiplicand
- in_b  in  OPW  multiplier
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- out_p  out  2*OPW  product in_a*in_b, unsigned
- busy  out  1  high in RUN or DONE
- core_x  out  4  digit of A to the 4x4 core
- core_y  out  4  digit of B to the 4x4 core
- core_o  in  8  core product, combinational from core_x/core_y

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE, acc=0, pass counter=0, operand regs=0.
  - out_valid=0, out_p=0, busy=0, core_x=0, core_y=0.
  - in_ready=1 once rst_n is high.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_a/in_b, clear acc and counter, go to RUN.
  - RUN: in_ready=0. Pass k (0..NPASS-1) uses i=k/NB and j=k%NB.
    - core_x = A digit i (bits 4i+3:4i); core_y = B digit j.
    - At each edge: acc <= acc + (core_o << 4*(i+j)).
    - After the edge for pass NPASS-1, go to DONE.
  - DONE: out_valid=1, out_p=acc, held stable until out_valid&&out_ready, then go to IDLE.
- Outside RUN: core_x=core_y=0.
- Latency and throughput:
  - out_valid rises exactly NPASS edges after the accepting edge (4 at OPW=8).
  - in_ready returns one cycle after the output handshake.
  - Throughput: one multiply per NPASS+2 cycles with out_ready held high.
- Arithmetic:
  - acc is 2*OPW bits and never overflows, since the final value is at most (2^OPW-1)^2.
  - No intermediate truncation; shifted terms beyond bit 2*OPW-1 are zero by construction.
- Boundary conditions:
  - in_valid in RUN/DONE is ignored (not accepted) and input changes have no effect.
  - out_ready low in DONE: hold indefinitely, no data change.
  - out_ready high outside DONE: no effect.
  - Reset mid-RUN/DONE: transaction dropped, no out_valid, outputs return to reset values immediately.
  - Maximum operands (all ones) and all-zero operands need no special case in the base build.

Optional Feature:
- Macro: MUL_SEQ_ZERO_BYPASS_EN.
- Defined: at accept, if in_a==0 or in_b==0, go IDLE->DONE directly with acc=0. out_valid rises 1 edge after accept; the core is not driven (core_x/core_y stay 0).
- Undefined: zero operands take the normal NPASS passes and give result 0.

Decomposition:
- Shared package mul_seq_pkg:
  - state enum {IDLE, RUN, DONE}
  - constant CORE_W=4
  - function npass(opw) returning (opw/4)^2
- Single module; no sub-module inside. The 4x4 core is instantiated alongside by the parent and connected via core_x/core_y/core_o.
- The bench instantiates the team's existing 4x4 combinational multiplier as the core.

Test Plan:
- A=8'hFF, B=8'hFF -> out_p=16'hFE01, out_valid 4 edges after accept; core_x/core_y sequence (F,F)x4.
- A=8'h0D, B=8'hB7 -> out_p=16'h094B; core pairs in order (D,7),(D,B),(0,7),(0,B).
- out_ready low for 5 cycles in DONE -> out_valid and out_p stable; in_valid=1 with new operands ignored (in_ready=0); release gives one handshake, in_ready=1 the next cycle.
- Back-to-back requests with out_ready tied high: 3x5 -> 16'h000F then 200x100 -> 16'h4E20, each correct and ordered.
- rst_n pulsed low during pass 2 of A=8'h12, B=8'h34 -> all outputs reset immediately, no out_valid; next request 8'h12x8'h34 -> 16'h03A8.
- A=0, B=8'h5A: with MUL_SEQ_ZERO_BYPASS_EN, out_p=0 after 1 edge and core inputs stay 0; without it, out_p=0 after 4 edges.
